// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared RV32I fetch definitions.
//   XLEN             - datapath width
//   INSTR_NOP        - canonical NOP (addi x0, x0, 0) shown to decode when idle
//   PC_STEP          - byte increment between sequential instructions
//   RESET_PC_DEFAULT - default first fetch address after reset
//   fetch_entry_t    - buffered {pc, instr} pair
//   word_align()     - clears the byte-offset bits of an address
package ifetch_unit_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: bus bundle between the fetch stage and its neighbours.
//   imem_req_*   - fetch request handshake (fetch -> instruction memory)
//   imem_resp_*  - in-order instruction return (memory -> fetch)
//   redirect_*   - taken branch/jump from execute
//   dec_*        - instruction hand-off to decode
// master: the fetch stage; slave: memory/execute/decode side.
interface ifetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// ifetch_unit_fetch_fifo: synchronous FIFO of {pc, instr} entries.
//   clk, rst_n  - clock, synchronous active-low reset
//   push/data   - write an entry at the tail
//   pop         - drop the head entry (ignored when empty)
//   flush       - empty the FIFO; overrides push and pop
//   head        - head entry, read straight from storage registers
//   count/full/empty - occupancy status
// Storage is register based so the head is visible the cycle after the push.
module ifetch_unit_fetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           push_en;
    logic           pop_en;
    logic [DEPTH-1:0] wr_sel;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign push_en = push && !flush;
    assign pop_en  = pop && !empty && !flush;
    assign head    = mem_reg[rd_ptr_reg];

    // One-hot write select per storage slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_en && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I instruction fetch stage.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - ifetch_unit_if.master: imem request/response, redirect,
//                decode hand-off
// Keeps the PC, issues one word request per credit, tags in-order responses
// with their PC and buffers them for decode. A redirect flushes the buffer
// and marks every still-pending response of the old stream for discard.
// Every output is derived from registered state only.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ifetch_unit_if.master     bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] resp_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   outstanding_next;

    logic            req_valid;
    logic            req_fire;
    logic            resp_fire;
    logic            keep_resp;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_wdata;

    // Credit: buffered entries plus in-flight requests never exceed DEPTH,
    // so every response always has a slot waiting for it.
    assign req_valid = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign resp_fire = bus.imem_resp_valid;

    assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(resp_fire);

    // A response is kept only if it belongs to the current stream.
    assign keep_resp  = resp_fire && (drop_cnt_reg == '0) && !bus.redirect_valid;
    assign fifo_pop   = !fifo_empty && bus.dec_ready;
    // Redundant with the credit rule; guards storage against a misbehaving memory.
    assign fifo_push  = keep_resp && (!fifo_full || fifo_pop);
    assign fifo_wdata = '{pc: resp_pc_reg, instr: bus.imem_resp_data};

    ifetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (bus.redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (bus.redirect_valid) begin
                // Everything still pending after this edge, including a
                // request that fires right now on the old pc, is stale.
                pc_reg       <= word_align(bus.redirect_pc);
                resp_pc_reg  <= word_align(bus.redirect_pc);
                drop_cnt_reg <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc_reg <= pc_reg + PC_STEP;
                end
                if (resp_fire) begin
                    if (drop_cnt_reg != '0) begin
                        drop_cnt_reg <= drop_cnt_reg - CW'(1);
                    end else begin
                        resp_pc_reg <= resp_pc_reg + PC_STEP;
                    end
                end
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_reg;
    assign bus.dec_valid      = !fifo_empty;
    assign bus.dec_instr      = fifo_empty ? INSTR_NOP : fifo_head.instr;
    assign bus.dec_pc         = fifo_empty ? '0 : fifo_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: self-checking bench for ifetch_unit.
// A small in-order memory model answers accepted requests after mem_lat
// cycles with mem_word(addr). Inputs change and outputs are checked on the
// falling edge; a per-cycle vector table covers the steady stream and the
// decode stall, hand-written sequences cover redirect, wrap and reset.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    logic clk;
    logic rst_n;
    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        rdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_dv;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t mem_q[$];
    vec_t  vecs[21];
    int    mem_lat;
    int    cyc;
    int    checks;
    int    errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs (called at a falling edge), account for the
    // handshakes that fire at the next rising edge, advance to the next falling edge.
    task automatic run_cycle(input logic rst, input logic rdy, input logic redir,
                             input logic [31:0] rpc);
        rst_n              = rst;
        bus.dec_ready      = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = 1'b1;
        if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(mem_q[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
        #1;
        if (!rst) begin
            mem_q.delete();
        end else begin
            if (bus.imem_resp_valid) void'(mem_q.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready)
                mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int lat);
        mem_lat = lat;
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cyc = 0;
    endtask

    task automatic chk_dec(input string name, input logic dv, input logic [31:0] pc);
        chk({name, "_dv"}, 32'(bus.dec_valid), 32'(dv));
        chk({name, "_pc"}, bus.dec_pc, pc);
        chk({name, "_instr"}, bus.dec_instr, dv ? mem_word(pc) : INSTR_NOP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.dec_ready       = 1'b1;

        // rdy, req_valid, req_addr, dec_valid, dec_pc  (1-cycle memory)
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[4]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[6]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 32'h14, 1'b0, 32'h00};
        vecs[8]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        for (int i = 9; i <= 16; i++) vecs[i] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[17] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[18] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
        vecs[19] = '{1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        vecs[20] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};

        // Stream from reset, then decode stalled for cycles 7..16.
        do_reset(1);
        for (int i = 0; i < 21; i++) begin
            chk("tbl_req_valid", 32'(bus.imem_req_valid), 32'(vecs[i].exp_rv));
            chk("tbl_req_addr", bus.imem_req_addr, vecs[i].exp_addr);
            chk_dec("tbl", vecs[i].exp_dv, vecs[i].exp_pc);
            run_cycle(1'b1, vecs[i].rdy, 1'b0, 32'h0);
        end
        $display("stream/stall table done at cycle %0d", cyc);

        // Redirect to 0x103 with two requests outstanding (3-cycle memory).
        do_reset(3);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir2_rv_before", 32'(bus.imem_req_valid), 32'h0);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("redir2_addr", bus.imem_req_addr, 32'h100);
        chk("redir2_dv", 32'(bus.dec_valid), 32'h0);
        chk("redir2_rv_held", 32'(bus.imem_req_valid), 32'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir2_rv_after", 32'(bus.imem_req_valid), 32'h1);
        chk("redir2_addr_after", bus.imem_req_addr, 32'h100);
        for (int k = 0; k < 20 && !bus.dec_valid; k++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir2_wait", 32'(bus.dec_valid), 32'h1);
        chk_dec("redir2_first", 1'b1, 32'h100);
        $display("redirect with two outstanding done at cycle %0d", cyc);

        // Redirect coinciding with a response and a request fire.
        do_reset(1);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_same_rv", 32'(bus.imem_req_valid), 32'h1);
        chk("redir_same_addr", bus.imem_req_addr, 32'h4);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk_dec("redir_same_flush", 1'b0, 32'h0);
        chk("redir_same_new_addr", bus.imem_req_addr, 32'h200);
        chk("redir_same_new_rv", 32'(bus.imem_req_valid), 32'h1);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_same_addr2", bus.imem_req_addr, 32'h204);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk_dec("redir_same_first", 1'b1, 32'h200);
        $display("redirect with response and request done at cycle %0d", cyc);

        // PC wrap at the top of the address space; low bits of target ignored.
        do_reset(1);
        run_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
        chk_dec("wrap_empty", 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr1", bus.imem_req_addr, 32'h0000_0000);
        chk("wrap_rv1", 32'(bus.imem_req_valid), 32'h1);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk_dec("wrap_dec0", 1'b1, 32'hFFFF_FFFC);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk_dec("wrap_dec1", 1'b1, 32'h0000_0000);
        $display("pc wrap done at cycle %0d", cyc);

        // One-cycle reset with the buffer full.
        do_reset(1);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk_dec("rst_mid_full", 1'b1, 32'h0);
        chk("rst_mid_full_rv", 32'(bus.imem_req_valid), 32'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_dec("rst_mid_after", 1'b0, 32'h0);
        chk("rst_mid_addr", bus.imem_req_addr, 32'h0);
        chk("rst_mid_rv", 32'(bus.imem_req_valid), 32'h1);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk_dec("rst_mid_restart", 1'b1, 32'h0);
        $display("reset mid-stream done at cycle %0d", cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
